load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
Multi-cycle data-memory access stage between the CPU execute stage and the SoC data memory. It takes one load or store per request from the core and aligns addresses into byte strobes. It runs a req/ack handshake with word-organised memory, then returns sign- or zero-extended load data. The core stalls on busy, so memory latency above one cycle needs no core changes.

Parameters:
ADDR_WIDTH, 32, byte-address width of req_addr and mem_addr.
TIMEOUT_CYCLES, 255, max cycles in WAIT_ACK before a bus-error response; must be at least 1.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
req_valid  input  1  core presents an access.
req_ready  output  1  high only in IDLE; request accepted on rising edge with req_valid&req_ready.
req_is_store  input  1  1 = store, 0 = load.
req_funct3  input  3  RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW).
req_addr  input  ADDR_WIDTH  byte address.
req_wdata  input  32  store data, right-aligned.
resp_valid  output  1  one-cycle completion pulse.
resp_rdata  output  32  extended load result; 0 for stores and errors.
resp_err  output  1  qualifies resp_valid: misaligned, illegal funct3 or timeout.
busy  output  1  high whenever state is not IDLE.
mem_req  output  1  bus request, registered.
mem_we  output  1  write enable.
mem_addr  output  ADDR_WIDTH  word-aligned address (low 2 bits 0).
mem_wstrb  output  4  byte-lane enables, 0 for loads.
mem_wdata  output  32  lane-replicated store data.
mem_rdata  input  32  read word, valid in mem_ack cycle.
mem_ack  input  1  completes the bus transfer.

Behaviour:
- Reset (async): state IDLE. All outputs 0 except req_ready=1. Timeout counter 0. A reset during WAIT_ACK drops mem_req immediately and produces no response.
- States: IDLE, WAIT_ACK, RESP.
- IDLE, on accept, checks legality:
  - Legal load funct3: 000, 001, 010, 100, 101. Legal store funct3: 000, 001, 010.
  - Alignment: halfword needs addr[0]=0; word needs addr[1:0]=0.
  - Illegal or misaligned: go to RESP with err=1, rdata=0. mem_req is never raised.
  - Legal: latch the access, drive mem_req=1 with mem_addr={addr[ADDR_WIDTH-1:2],2'b00}, counter=0, go to WAIT_ACK.
- WAIT_ACK:
  - mem_req, mem_we, mem_addr, mem_wstrb and mem_wdata are held stable until ack.
  - On mem_ack at a rising edge: drop mem_req, capture the load result, go to RESP with err=0.
  - Otherwise the counter increments. When the counter reaches TIMEOUT_CYCLES, drop mem_req and go to RESP with err=1.
  - If ack and timeout coincide on the same edge, ack wins.
- RESP: resp_valid=1 for exactly one cycle, then IDLE. There is no backpressure. req_ready=0 during RESP, so back-to-back accesses are spaced by at least one idle cycle.
- mem_ack outside WAIT_ACK is ignored.
- Latency with mem_ack tied high: accept at edge E0, mem_req high E0 to E1, resp_valid high E1 to E2.
- Store lanes, with o=addr[1:0]:
  - SB: wstrb=4'b0001<<o, wdata={4{wdata[7:0]}}.
  - SH: wstrb=4'b0011<<o, wdata={2{wdata[15:0]}}.
  - SW: wstrb=4'b1111, wdata unchanged.
  - Loads: wstrb=0, mem_we=0.
- Load extract, with o=addr[1:0]:
  - Byte = mem_rdata[8o+7:8o]. LB sign-extends; LBU zero-extends.
  - Halfword = mem_rdata[16*addr[1]+15:16*addr[1]]. LH sign-extends; LHU zero-extends.
  - LW takes the whole word.
- resp_rdata and resp_err hold their last value only during RESP and are 0 otherwise.

Test Plan:
- LBU addr 0x1003, memory word 0x80FF1234, ack after 3 wait cycles -> mem_addr 0x1000, wstrb 0, resp_rdata 0x00000080, err 0. LB same address -> 0xFFFFFF80.
- SH addr 0x0102, wdata 0x1234ABCD, ack immediate -> mem_we 1, mem_addr 0x0100, wstrb 4'b1100, wdata 0xABCDABCD, resp_valid E1 to E2, rdata 0.
- LW addr 0x0002 -> no mem_req at any cycle, resp_valid with err 1 one cycle after accept. Store funct3 100 -> same error.
- TIMEOUT_CYCLES=4, mem_ack never asserted -> mem_req high exactly 4 cycles then low, resp_err 1. Ack on the 4th-cycle edge -> err 0.
- Reset asserted mid-WAIT_ACK -> mem_req, busy and resp_valid go 0 without waiting for a clock edge. After release: req_ready 1, no stale response.
- LHU addr 0x0006 after SB addr 0x0007 data 0x5A (memory model updated) -> SB strobe 4'b1000. LHU returns 0x00005A00 when byte 6 = 0x00.

Source files
------------

// File: rtl/load_store_unit_if.sv
// load_store_unit_if: core request/response channel and word-organised data-memory bus.
interface load_store_unit_if #(parameter int ADDR_WIDTH = 32);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_is_store;
  logic [2:0]            req_funct3;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [31:0]           req_wdata;
  logic                  resp_valid;
  logic [31:0]           resp_rdata;
  logic                  resp_err;
  logic                  busy;
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [3:0]            mem_wstrb;
  logic [31:0]           mem_wdata;
  logic [31:0]           mem_rdata;
  logic                  mem_ack;
  modport slave (
    input  req_valid, req_is_store, req_funct3, req_addr, req_wdata, mem_rdata, mem_ack,
    output req_ready, resp_valid, resp_rdata, resp_err, busy,
           mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata
  );
  modport master (
    output req_valid, req_is_store, req_funct3, req_addr, req_wdata, mem_rdata, mem_ack,
    input  req_ready, resp_valid, resp_rdata, resp_err, busy,
           mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata
  );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: turns one core load/store into a req/ack word access with byte lanes,
// returning extended load data or an error (illegal, misaligned, timeout).
module load_store_unit #(
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic              clk,
  input logic              reset,
  load_store_unit_if.slave bus
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, WAIT_ACK, RESP} state_t;
  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  we_q, we_d, err_q, err_d;
  logic [2:0]            f3_q, f3_d;
  logic [1:0]            off_q, off_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [3:0]            strb_q, strb_d;
  logic [31:0]           wdata_q, wdata_d, rdata_q, rdata_d;
  logic                  legal, aligned, timeout;
  logic [1:0]            off;
  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;
  logic [31:0]           ld_data;
  assign off     = bus.req_addr[1:0];
  assign legal   = bus.req_is_store ? (bus.req_funct3 inside {3'b000, 3'b001, 3'b010})
                                    : (bus.req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
  assign aligned = bus.req_funct3[1:0] == 2'b01 ? !off[0] :
                   bus.req_funct3[1:0] == 2'b10 ? off == 2'b00 : 1'b1;
  // ack on the same edge as the last allowed cycle takes priority over this
  assign timeout = cnt_q == CW'(TIMEOUT_CYCLES - 1);
  assign ld_byte = 8'(bus.mem_rdata >> {off_q, 3'b000});
  assign ld_half = off_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
  assign ld_data = we_q ? '0 :
                   f3_q[1:0] == 2'b00 ? {{24{~f3_q[2] & ld_byte[7]}}, ld_byte} :
                   f3_q[1:0] == 2'b01 ? {{16{~f3_q[2] & ld_half[15]}}, ld_half} : bus.mem_rdata;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    f3_d    = f3_q;
    off_d   = off_q;
    addr_d  = addr_q;
    strb_d  = strb_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (bus.req_valid) begin
        if (legal && aligned) begin
          state_d = WAIT_ACK;
          cnt_d   = '0;
          we_d    = bus.req_is_store;
          f3_d    = bus.req_funct3;
          off_d   = off;
          addr_d  = {bus.req_addr[ADDR_WIDTH-1:2], 2'b00};
          strb_d  = !bus.req_is_store ? 4'b0000 :
                    bus.req_funct3[1:0] == 2'b00 ? 4'b0001 << off :
                    bus.req_funct3[1:0] == 2'b01 ? 4'b0011 << off : 4'b1111;
          wdata_d = !bus.req_is_store ? '0 :
                    bus.req_funct3[1:0] == 2'b00 ? {4{bus.req_wdata[7:0]}} :
                    bus.req_funct3[1:0] == 2'b01 ? {2{bus.req_wdata[15:0]}} : bus.req_wdata;
        end else begin
          state_d = RESP;
          err_d   = 1'b1;
          rdata_d = '0;
        end
      end
      WAIT_ACK: if (bus.mem_ack) begin
        state_d = RESP;
        err_d   = 1'b0;
        rdata_d = ld_data;
      end else if (timeout) begin
        state_d = RESP;
        err_d   = 1'b1;
        rdata_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      f3_q    <= '0;
      off_q   <= '0;
      addr_q  <= '0;
      strb_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      off_q   <= off_d;
      addr_q  <= addr_d;
      strb_q  <= strb_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end
  // bus and response fields are gated by state so reset clears them without an edge
  assign bus.req_ready  = state_q == IDLE;
  assign bus.busy       = state_q != IDLE;
  assign bus.resp_valid = state_q == RESP;
  assign bus.resp_rdata = bus.resp_valid ? rdata_q : '0;
  assign bus.resp_err   = bus.resp_valid & err_q;
  assign bus.mem_req    = state_q == WAIT_ACK;
  assign bus.mem_we     = bus.mem_req & we_q;
  assign bus.mem_addr   = bus.mem_req ? addr_q : '0;
  assign bus.mem_wstrb  = bus.mem_req ? strb_q : '0;
  assign bus.mem_wdata  = bus.mem_req ? wdata_q : '0;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed accesses against a word memory model, checked by scoreboard monitors.
module tb_load_store_unit;
  localparam int AW = 32;
  localparam int TO = 4;
  typedef struct packed {logic [31:0] rdata; logic err;} resp_t;
  typedef struct packed {logic we; logic [31:0] addr; logic [3:0] strb; logic [31:0] wdata;} mreq_t;
  logic clk = 0;
  logic reset = 1;
  always #5 clk = ~clk;
  load_store_unit_if #(.ADDR_WIDTH(AW)) bus ();
  load_store_unit #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (.clk(clk), .reset(reset), .bus(bus));
  resp_t       resp_q[$];
  mreq_t       mreq_q[$];
  logic [31:0] mem [0:4095];
  int checks = 0, errors = 0;
  int ack_delay = 0, rises = 0, req_cycles = 0;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  initial begin
    int wc;
    int idx;
    wc = 0;
    bus.mem_ack   = 0;
    bus.mem_rdata = 32'hA5A5A5A5;
    forever begin
      @(negedge clk);
      if (bus.mem_req && !bus.mem_ack) begin
        if (wc == ack_delay) begin
          idx = int'(bus.mem_addr[13:2]);
          bus.mem_ack   = 1;
          bus.mem_rdata = mem[idx];
          if (bus.mem_we)
            for (int b = 0; b < 4; b++)
              if (bus.mem_wstrb[b]) mem[idx][8*b +: 8] = bus.mem_wdata[8*b +: 8];
        end else wc++;
      end else begin
        bus.mem_ack   = 0;
        bus.mem_rdata = 32'hA5A5A5A5;
        wc = 0;
      end
    end
  end
  initial begin
    resp_t e;
    mreq_t m;
    logic  prev;
    prev = 0;
    forever begin
      @(negedge clk);
      if (bus.resp_valid) begin
        if (resp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_resp: rdata %0h err %0b with nothing outstanding", bus.resp_rdata, bus.resp_err);
        end else begin
          e = resp_q.pop_front();
          check("resp_rdata", bus.resp_rdata, e.rdata);
          check("resp_err", bus.resp_err, e.err);
        end
      end else check("resp_idle_zero", {bus.resp_rdata, bus.resp_err}, 0);
      if (bus.mem_req && !prev) begin
        rises++;
        req_cycles = 1;
        if (mreq_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_mem_req: addr %0h", bus.mem_addr);
        end else begin
          m = mreq_q.pop_front();
          check("mem_we", bus.mem_we, m.we);
          check("mem_addr", bus.mem_addr, m.addr);
          check("mem_wstrb", bus.mem_wstrb, m.strb);
          check("mem_wdata", bus.mem_wdata, m.wdata);
        end
      end else if (bus.mem_req) req_cycles++;
      prev = bus.mem_req;
    end
  end
  task automatic access(input logic st, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata,
                        input int delay, input logic [31:0] exp_rdata, input logic exp_err, input logic exp_mem,
                        input logic [31:0] exp_maddr, input logic [3:0] exp_strb, input logic [31:0] exp_wdata,
                        input int exp_lat, input int exp_cycles);
    int r0, lat;
    @(negedge clk);
    check("req_ready_idle", bus.req_ready, 1);
    ack_delay        = delay;
    bus.req_valid    = 1;
    bus.req_is_store = st;
    bus.req_funct3   = f3;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
    resp_q.push_back(resp_t'{exp_rdata, exp_err});
    if (exp_mem) mreq_q.push_back(mreq_t'{st, exp_maddr, exp_strb, exp_wdata});
    r0 = rises;
    @(posedge clk);
    #1;
    bus.req_valid    = 0;
    bus.req_is_store = ~st;
    bus.req_funct3   = 3'b111;
    bus.req_addr     = 32'hFFFFFFFF;
    bus.req_wdata    = 32'hDEADDEAD;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.resp_valid && lat < 20);
    check("latency", lat, exp_lat);
    check("mem_req_rises", rises - r0, exp_mem ? 1 : 0);
    if (exp_mem) check("mem_req_cycles", req_cycles, exp_cycles);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.req_valid = 0; bus.req_is_store = 0; bus.req_funct3 = 0; bus.req_addr = 0; bus.req_wdata = 0;
    for (int i = 0; i < 4096; i++) mem[i] = 0;
    mem[32'h1000 >> 2] = 32'h80FF1234;
    mem[1]             = 32'h11003344;
    mem[32'h0200 >> 2] = 32'hDEADBEEF;
    #1;
    check("rst_req_ready", bus.req_ready, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_mem_req", bus.mem_req, 0);
    check("rst_resp", {bus.resp_valid, bus.resp_rdata, bus.resp_err}, 0);
    check("rst_mem_bus", {bus.mem_we, bus.mem_addr, bus.mem_wstrb, bus.mem_wdata}, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 0;
    //     st  f3      addr          wdata         dly rdata         err mem maddr         strb     wdata         lat cyc
    access(0, 3'b100, 32'h00001003, 32'h0,        3, 32'h00000080, 0, 1, 32'h00001000, 4'b0000, 32'h0,        5, 4);
    access(0, 3'b000, 32'h00001003, 32'h0,        3, 32'hFFFFFF80, 0, 1, 32'h00001000, 4'b0000, 32'h0,        5, 4);
    access(1, 3'b001, 32'h00000102, 32'h1234ABCD, 0, 32'h0,        0, 1, 32'h00000100, 4'b1100, 32'hABCDABCD, 2, 1);
    access(0, 3'b010, 32'h00000002, 32'h0,        0, 32'h0,        1, 0, 32'h0,        4'b0000, 32'h0,        1, 0);
    access(1, 3'b100, 32'h00000000, 32'h0,        0, 32'h0,        1, 0, 32'h0,        4'b0000, 32'h0,        1, 0);
    access(0, 3'b010, 32'h00000200, 32'h0,       -1, 32'h0,        1, 1, 32'h00000200, 4'b0000, 32'h0,        5, 4);
    access(0, 3'b010, 32'h00000200, 32'h0,        3, 32'hDEADBEEF, 0, 1, 32'h00000200, 4'b0000, 32'h0,        5, 4);
    access(1, 3'b000, 32'h00000007, 32'h1234565A, 1, 32'h0,        0, 1, 32'h00000004, 4'b1000, 32'h5A5A5A5A, 3, 2);
    access(0, 3'b101, 32'h00000006, 32'h0,        0, 32'h00005A00, 0, 1, 32'h00000004, 4'b0000, 32'h0,        2, 1);
    access(0, 3'b001, 32'h00001002, 32'h0,        2, 32'hFFFF80FF, 0, 1, 32'h00001000, 4'b0000, 32'h0,        4, 3);
    access(0, 3'b101, 32'h00001002, 32'h0,        0, 32'h000080FF, 0, 1, 32'h00001000, 4'b0000, 32'h0,        2, 1);
    access(0, 3'b000, 32'h00001001, 32'h0,        0, 32'h00000012, 0, 1, 32'h00001000, 4'b0000, 32'h0,        2, 1);
    access(1, 3'b010, 32'h00000010, 32'hCAFEF00D, 0, 32'h0,        0, 1, 32'h00000010, 4'b1111, 32'hCAFEF00D, 2, 1);
    access(0, 3'b010, 32'h00000010, 32'h0,        0, 32'hCAFEF00D, 0, 1, 32'h00000010, 4'b0000, 32'h0,        2, 1);
    access(0, 3'b001, 32'h00000003, 32'h0,        0, 32'h0,        1, 0, 32'h0,        4'b0000, 32'h0,        1, 0);
    access(0, 3'b011, 32'h00000000, 32'h0,        0, 32'h0,        1, 0, 32'h0,        4'b0000, 32'h0,        1, 0);
    access(1, 3'b010, 32'h00000101, 32'h0,        0, 32'h0,        1, 0, 32'h0,        4'b0000, 32'h0,        1, 0);
    // reset in the middle of an unanswered access
    @(negedge clk);
    ack_delay        = -1;
    bus.req_valid    = 1;
    bus.req_is_store = 0;
    bus.req_funct3   = 3'b010;
    bus.req_addr     = 32'h00000200;
    mreq_q.push_back(mreq_t'{1'b0, 32'h00000200, 4'b0000, 32'h0});
    @(posedge clk);
    #1;
    bus.req_valid = 0;
    @(negedge clk);
    @(negedge clk);
    check("pre_reset_mem_req", bus.mem_req, 1);
    #2;
    reset = 1;
    #1;
    check("async_rst_mem_req", bus.mem_req, 0);
    check("async_rst_busy", bus.busy, 0);
    check("async_rst_resp_valid", bus.resp_valid, 0);
    check("async_rst_req_ready", bus.req_ready, 1);
    @(negedge clk);
    reset = 0;
    repeat (4) @(negedge clk);
    check("post_rst_req_ready", bus.req_ready, 1);
    check("post_rst_busy", bus.busy, 0);
    check("queues_drained", resp_q.size() + mreq_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
